// File: rtl/core_bus_master.sv
// core_bus_master: CPU-side master for a 4-phase req/ack bus (IDLE -> REQ -> RELEASE).
// A CPU request is latched onto registered bus outputs. The bus is held until the
// responder acks, and read data is returned to the register file with a one-cycle
// valid pulse.
// Optional feature: define CORE_BUS_TIMEOUT_EN to abort a REQ phase that has been
// waiting for TIMEOUT_CYCLES cycles. An aborted read returns 16'hFFFF and pulses err.
module core_bus_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_start,
   input  logic        cpu_write,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic        busy,
   output logic [15:0] rdata,
   output logic        rdata_valid,
   output logic        done,
   output logic        err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [15:0] bus_addr,
   output logic [15:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [15:0] bus_rdata
);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StReq     = 2'd1;
   localparam logic [1:0] StRelease = 2'd2;

   // A zero timeout would abort before the request is ever visible on the bus.
   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("core_bus_master: TIMEOUT_CYCLES must be at least 1");
   end

   logic [1:0]  state_q, state_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic        rdata_valid_q, rdata_valid_d;
   logic        done_q, done_d;

`ifdef CORE_BUS_TIMEOUT_EN
   localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
   // The counter holds the number of REQ cycles already spent, so the abort
   // happens on the edge that ends the TIMEOUT_CYCLES-th REQ cycle.
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   logic            err_q, err_d;
   logic [CntW-1:0] cnt_q, cnt_d;
`endif

   // Next-state logic for the handshake FSM and all registered outputs.
   always_comb begin
      state_d       = state_q;
      req_d         = req_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      done_d        = 1'b0;
`ifdef CORE_BUS_TIMEOUT_EN
      err_d         = 1'b0;
      cnt_d         = cnt_q;
`endif

      unique case (state_q)
         StIdle: begin
            // bus_ack is deliberately ignored here.
            if (cpu_start) begin
               we_d    = cpu_write;
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
               req_d   = 1'b1;
               state_d = StReq;
`ifdef CORE_BUS_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         StReq: begin
            // An ack takes precedence over a timeout that expires on the same edge.
            if (bus_ack) begin
               req_d   = 1'b0;
               done_d  = 1'b1;
               state_d = StRelease;
               if (!we_q) begin
                  rdata_d       = bus_rdata;
                  rdata_valid_d = 1'b1;
               end
            end
`ifdef CORE_BUS_TIMEOUT_EN
            else if (cnt_q == CntLast) begin
               req_d   = 1'b0;
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = StIdle;
               if (!we_q) begin
                  rdata_d       = 16'hFFFF;
                  rdata_valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
`endif
         end
         StRelease: begin
            if (!bus_ack) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            req_d   = 1'b0;
         end
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         req_q         <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         done_q        <= 1'b0;
`ifdef CORE_BUS_TIMEOUT_EN
         err_q         <= 1'b0;
         cnt_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         req_q         <= req_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         done_q        <= done_d;
`ifdef CORE_BUS_TIMEOUT_EN
         err_q         <= err_d;
         cnt_q         <= cnt_d;
`endif
      end
   end

   // Output drive: everything comes straight from registers.
   always_comb begin
      busy        = (state_q != StIdle);
      rdata       = rdata_q;
      rdata_valid = rdata_valid_q;
      done        = done_q;
      bus_req     = req_q;
      bus_we      = we_q;
      bus_addr    = addr_q;
      bus_wdata   = wdata_q;
`ifdef CORE_BUS_TIMEOUT_EN
      err         = err_q;
`else
      err         = 1'b0;
`endif
   end

endmodule

// File: tb/tb_core_bus_master.sv
// tb_core_bus_master: directed self-checking bench for core_bus_master.
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
// The timeout scenarios are compiled in only when CORE_BUS_TIMEOUT_EN is defined.
module tb_core_bus_master;

   logic        clk;
   logic        rst;
   logic        cpu_start;
   logic        cpu_write;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        busy;
   logic [15:0] rdata;
   logic        rdata_valid;
   logic        done;
   logic        err;
   logic        bus_req;
   logic        bus_we;
   logic [15:0] bus_addr;
   logic [15:0] bus_wdata;
   logic        bus_ack;
   logic [15:0] bus_rdata;

   int n_tests;
   int n_fail;

   core_bus_master #(
      .TIMEOUT_CYCLES(8)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_start  (cpu_start),
      .cpu_write  (cpu_write),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .busy       (busy),
      .rdata      (rdata),
      .rdata_valid(rdata_valid),
      .done       (done),
      .err        (err),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_ack    (bus_ack),
      .bus_rdata  (bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [9:0] exp_req;
      logic [9:0] exp_busy;
      logic [9:0] exp_done;
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b1;
      cpu_start = 1'b0;
      cpu_write = 1'b0;
      cpu_addr  = 16'h0;
      cpu_wdata = 16'h0;
      bus_ack   = 1'b0;
      bus_rdata = 16'h0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check_eq("rst_busy", busy, 0);
      check_eq("rst_rdata", rdata, 0);
      check_eq("rst_req", bus_req, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_addr", bus_addr, 0);

      // Ack while idle is ignored
      bus_ack = 1'b1;
      tick();
      check_eq("idleack_busy", busy, 0);
      check_eq("idleack_done", done, 0);
      bus_ack = 1'b0;

      // Read 0x1234, ack arrives two cycles after req
      cpu_start = 1'b1;
      cpu_write = 1'b0;
      cpu_addr  = 16'h1234;
      tick();
      cpu_start = 1'b0;
      check_eq("rd_busy", busy, 1);
      check_eq("rd_req", bus_req, 1);
      check_eq("rd_we", bus_we, 0);
      check_eq("rd_addr", bus_addr, 16'h1234);
      tick();
      check_eq("rd_req_wait", bus_req, 1);
      check_eq("rd_done_wait", done, 0);
      bus_ack   = 1'b1;
      bus_rdata = 16'hBEEF;
      tick();
      check_eq("rd_req_low", bus_req, 0);
      check_eq("rd_rdata", rdata, 16'hBEEF);
      check_eq("rd_valid", rdata_valid, 1);
      check_eq("rd_done", done, 1);
      check_eq("rd_err", err, 0);
      check_eq("rd_busy_rel", busy, 1);
      bus_ack = 1'b0;
      tick();
      check_eq("rd_valid_off", rdata_valid, 0);
      check_eq("rd_done_off", done, 0);
      check_eq("rd_idle", busy, 0);
      check_eq("rd_hold", rdata, 16'hBEEF);

      // Write 0x0010 <= 0xA5A5; CPU inputs change mid-transaction
      cpu_start = 1'b1;
      cpu_write = 1'b1;
      cpu_addr  = 16'h0010;
      cpu_wdata = 16'hA5A5;
      tick();
      cpu_start = 1'b0;
      cpu_addr  = 16'hFFFF;
      cpu_wdata = 16'h0000;
      cpu_write = 1'b0;
      check_eq("wr_we", bus_we, 1);
      check_eq("wr_wdata", bus_wdata, 16'hA5A5);
      check_eq("wr_req", bus_req, 1);
      tick();
      check_eq("wr_wdata_hold", bus_wdata, 16'hA5A5);
      check_eq("wr_addr_hold", bus_addr, 16'h0010);
      check_eq("wr_we_hold", bus_we, 1);
      bus_ack   = 1'b1;
      bus_rdata = 16'h1111;
      tick();
      check_eq("wr_done", done, 1);
      check_eq("wr_valid", rdata_valid, 0);
      check_eq("wr_rdata", rdata, 16'hBEEF);
      check_eq("wr_req_low", bus_req, 0);
      check_eq("wr_wdata_rel", bus_wdata, 16'hA5A5);
      bus_ack = 1'b0;
      tick();
      check_eq("wr_idle", busy, 0);
      check_eq("wr_done_off", done, 0);

      // cpu_start held 10 cycles, ack held 4 cycles: one transaction, then a second
      // Per edge 1..10 (bit 0 = edge 1)
      exp_req  = 10'b1111000001;
      exp_busy = 10'b1111011111;
      exp_done = 10'b0000000010;
      cpu_start = 1'b1;
      cpu_write = 1'b0;
      cpu_addr  = 16'h0042;
      bus_rdata = 16'h5555;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq($sformatf("hold_req_%0d", i + 1), bus_req, exp_req[i]);
         check_eq($sformatf("hold_busy_%0d", i + 1), busy, exp_busy[i]);
         check_eq($sformatf("hold_done_%0d", i + 1), done, exp_done[i]);
         if (i == 0) bus_ack = 1'b1;
         if (i == 4) bus_ack = 1'b0;
      end
      cpu_start = 1'b0;
      check_eq("hold_rdata", rdata, 16'h5555);
      bus_rdata = 16'h7777;
      bus_ack   = 1'b1;
      tick();
      check_eq("hold2_rdata", rdata, 16'h7777);
      check_eq("hold2_done", done, 1);
      bus_ack = 1'b0;
      tick();
      check_eq("hold2_idle", busy, 0);

      // Reset during REQ, with ack present to show rst priority
      cpu_start = 1'b1;
      cpu_addr  = 16'h0099;
      tick();
      cpu_start = 1'b0;
      check_eq("mrst_req_pre", bus_req, 1);
      rst       = 1'b1;
      bus_ack   = 1'b1;
      bus_rdata = 16'h3333;
      tick();
      check_eq("mrst_req", bus_req, 0);
      check_eq("mrst_busy", busy, 0);
      check_eq("mrst_rdata", rdata, 0);
      check_eq("mrst_done", done, 0);
      check_eq("mrst_valid", rdata_valid, 0);
      rst     = 1'b0;
      bus_ack = 1'b0;
      tick();
      check_eq("mrst_done_after", done, 0);
      check_eq("mrst_busy_after", busy, 0);

`ifdef CORE_BUS_TIMEOUT_EN
      // Read with no ack: 8 REQ cycles, then abort
      cpu_start = 1'b1;
      cpu_write = 1'b0;
      cpu_addr  = 16'h0BAD;
      tick();
      cpu_start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         check_eq($sformatf("to_wait_%0d", i), busy, 1);
      end
      check_eq("to_req_last", bus_req, 1);
      tick();
      check_eq("to_busy", busy, 0);
      check_eq("to_req", bus_req, 0);
      check_eq("to_err", err, 1);
      check_eq("to_done", done, 1);
      check_eq("to_valid", rdata_valid, 1);
      check_eq("to_rdata", rdata, 16'hFFFF);
      tick();
      check_eq("to_err_off", err, 0);
      check_eq("to_done_off", done, 0);

      // Ack on the timeout edge wins
      cpu_start = 1'b1;
      cpu_addr  = 16'h0CAF;
      tick();
      cpu_start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      bus_ack   = 1'b1;
      bus_rdata = 16'hCAFE;
      tick();
      check_eq("race_err", err, 0);
      check_eq("race_done", done, 1);
      check_eq("race_rdata", rdata, 16'hCAFE);
      check_eq("race_busy", busy, 1);
      check_eq("race_req", bus_req, 0);
      bus_ack = 1'b0;
      tick();
      check_eq("race_idle", busy, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/core_bus_master.md
CORE_BUS_MASTER -- requirements
Module: core_bus_master

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 255, giving the REQ-state cycles before abort (used only with CORE_BUS_TIMEOUT_EN).
REQ-002 The module SHALL have port clk  input  1  clock; all logic is clocked on the rising edge.
REQ-003 The module SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The module SHALL have port cpu_start  input  1  transaction request, sampled only in IDLE.
REQ-005 The module SHALL have port cpu_write  input  1  1=write, 0=read; sampled with cpu_start.
REQ-006 The module SHALL have port cpu_addr  input  16  word address; sampled with cpu_start.
REQ-007 The module SHALL have port cpu_wdata  input  16  write data; sampled with cpu_start.
REQ-008 The module SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 The module SHALL have port rdata  output  16  last read data; drives the register file bus_datain.
REQ-010 The module SHALL have port rdata_valid  output  1  one-cycle pulse on read completion; drives the register file bus_fromin.
REQ-011 The module SHALL have port done  output  1  one-cycle pulse on any completion (read, write or timeout).
REQ-012 The module SHALL have port err  output  1  one-cycle pulse, coincident with done, on timeout.
REQ-013 The module SHALL have ports bus_req (output 1), bus_we (output 1), bus_addr (output 16) and bus_wdata (output 16), all registered.
REQ-014 The module SHALL have ports bus_ack (input 1) and bus_rdata (input 16), driven by the external responder.

Function
REQ-015 The module SHALL run a 4-phase req/ack handshake using states IDLE, REQ and RELEASE.
REQ-016 In IDLE, when cpu_start=1, the module SHALL latch cpu_write, cpu_addr and cpu_wdata into bus_we, bus_addr and bus_wdata, set bus_req=1 and enter REQ on the same edge.
REQ-017 In REQ, when bus_ack=1 is sampled, the module SHALL clear bus_req, enter RELEASE, and on a read capture bus_rdata into rdata on that edge.
REQ-018 rdata_valid (read only) and done SHALL be registered and high for exactly the one cycle after the capturing edge.
REQ-019 In RELEASE, the module SHALL stay until bus_ack=0 is sampled, then enter IDLE; bus_req SHALL remain 0 throughout.
REQ-020 cpu_start SHALL be ignored while busy=1, and the latched bus_addr, bus_we and bus_wdata SHALL stay constant from REQ entry until IDLE.
REQ-021 rdata SHALL hold its value until the next read capture; writes and timeouts-on-write SHALL leave it unchanged.
REQ-022 Minimum transaction length SHALL be: start edge, ack-seen edge, ack-low edge, giving 3 cycles start-to-IDLE when ack=1 for one cycle.
REQ-023 bus_ack=1 sampled in IDLE SHALL be ignored.

Reset
REQ-024 With rst=1 at a clock edge, the module SHALL enter IDLE and clear busy, rdata, rdata_valid, done, err, bus_req, bus_we, bus_addr, bus_wdata and the timeout counter to 0.
REQ-025 rst SHALL take priority over cpu_start and bus_ack, and reset mid-transaction SHALL drop bus_req on that edge with no done or rdata_valid pulse.

Configuration
REQ-026 When CORE_BUS_TIMEOUT_EN is defined, a counter SHALL clear on REQ entry and increment each cycle in REQ.
REQ-027 With CORE_BUS_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES without ack, the module SHALL clear bus_req, pulse done and err, go directly to IDLE, and on a read load rdata=16'hFFFF and pulse rdata_valid.
REQ-028 With CORE_BUS_TIMEOUT_EN, ack arriving on the same edge as timeout SHALL win (normal completion, err=0).
REQ-029 When CORE_BUS_TIMEOUT_EN is undefined, REQ SHALL wait indefinitely, err SHALL be tied 0 and no counter SHALL exist.

Verification
REQ-030 The bench SHALL cover: read addr=16'h1234, responder returns 16'hBEEF with ack 2 cycles after req -> rdata=16'hBEEF, rdata_valid and done one cycle each, bus_req low after ack.
REQ-031 The bench SHALL cover: write addr=16'h0010, wdata=16'hA5A5 -> bus_we=1, bus_wdata=16'hA5A5 stable until ack, done pulse, rdata_valid=0, rdata unchanged.
REQ-032 The bench SHALL cover: cpu_start held high for 10 cycles with ack held high 4 cycles -> exactly one transaction until RELEASE exits, then a second starts from IDLE.
REQ-033 The bench SHALL cover: rst asserted while in REQ -> next cycle bus_req=0, busy=0, rdata=0, no done pulse.
REQ-034 The bench SHALL cover, with CORE_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, a read with no ack -> after 8 REQ cycles rdata=16'hFFFF, err, done and rdata_valid pulse, busy=0.
REQ-035 The bench SHALL cover, with CORE_BUS_TIMEOUT_EN, ack arriving exactly on the timeout cycle -> normal completion with err=0 and captured data.
